// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD counter family: digit width, digit limits
// and the digit validity check used by load validation.
package bcd_pkg;

  // Width of one decade digit.
  localparam int BCD_W = 4;

  // Largest and smallest legal digit values.
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

  // One decade digit.
  typedef logic [BCD_W-1:0] bcd_digit_t;

  // True when a 4-bit value is a legal decimal digit (0..9).
  function automatic logic bcd_valid(input bcd_digit_t digit);
    return (digit <= BCD_MAX);
  endfunction

endpackage : bcd_pkg

// File: rtl/bcd_digit.sv
// One decade cell of the BCD counter. It steps up or down when told to,
// wrapping 9->0 (up) or 0->9 (down), and reports whether it currently sits
// at 9 or 0 so the parent can build the carry/borrow chain.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  input  logic       down,
  input  logic       ld,
  input  logic [3:0] ld_val,
  output logic [3:0] q,
  output logic       at_max,
  output logic       at_min
);

  logic [3:0] r_q;
  logic [3:0] w_next;

  // Next value of this digit if it steps in the current direction.
  always_comb begin
    w_next = r_q;
    if (down) begin
      if (r_q == BCD_MIN) w_next = BCD_MAX;
      else                w_next = r_q - 4'd1;
    end else begin
      // Treat anything at or above 9 as the roll-over point so the cell
      // can never walk into 10..15 even from an unexpected value.
      if (r_q >= BCD_MAX) w_next = BCD_MIN;
      else                w_next = r_q + 4'd1;
    end
  end

  // Digit register: reset beats load, load beats step.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= BCD_MIN;
    end else if (ld) begin
      r_q <= ld_val;
    end else if (step) begin
      r_q <= w_next;
    end
  end

  assign q      = r_q;
  assign at_max = (r_q == BCD_MAX);
  assign at_min = (r_q == BCD_MIN);

endmodule : bcd_digit

// File: rtl/bcd_counter_n.sv
// Multi-digit BCD up/down counter with validated parallel load, wrap or
// saturate behaviour at the range ends, and a combinational terminal count
// so instances can be cascaded (tc of one stage drives x of the next).
//
// Handshake: there is no valid/ready pair here. x, load and reset are
// single-cycle strobes sampled on every rising clk edge with priority
// reset > load > x; each accepted strobe takes effect on that edge.
module bcd_counter_n
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter bit WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  x,
  input  logic                  down,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  tc,
  output logic                  wrap_p,
  output logic                  sat,
  output logic                  load_err
);

  logic [DIGITS-1:0] w_at_max;
  logic [DIGITS-1:0] w_at_min;
  logic [DIGITS-1:0] w_step;
  logic [DIGITS-1:0] w_digit_ok;

  logic w_all_max;
  logic w_all_min;
  logic w_at_end;
  logic w_count;
  logic w_blocked;
  logic w_wrap;
  logic w_step_en;
  logic w_load_ok;
  logic w_load_do;

  logic r_wrap_p;
  logic r_sat;
  logic r_load_err;

  // Range-end detection and the decision of whether this edge steps.
  always_comb begin
    w_all_max = &w_at_max;
    w_all_min = &w_at_min;
    w_at_end  = down ? w_all_min : w_all_max;
    // A count request only matters when no load competes with it.
    w_count   = x & ~load;
    // At the range end the counter either rolls over or refuses the step.
    w_blocked = w_count & w_at_end & ~WRAP;
    w_wrap    = w_count & w_at_end & WRAP;
    w_step_en = w_count & ~w_blocked;
  end

  // Load is all-or-nothing: a single bad digit rejects the whole value.
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      w_digit_ok[i] = bcd_valid(load_val[4*i +: 4]);
    end
    w_load_ok = &w_digit_ok;
    w_load_do = load & w_load_ok;
  end

  // Carry/borrow chain: digit i steps when every lower digit is at the
  // roll-over value for the current direction.
  always_comb begin
    w_step[0] = w_step_en;
    for (int i = 1; i < DIGITS; i++) begin
      w_step[i] = w_step[i-1] & (down ? w_at_min[i-1] : w_at_max[i-1]);
    end
  end

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit u_digit (
        .clk    (clk),
        .reset  (reset),
        .step   (w_step[g]),
        .down   (down),
        .ld     (w_load_do),
        .ld_val (load_val[4*g +: 4]),
        .q      (bcd_out[4*g +: 4]),
        .at_max (w_at_max[g]),
        .at_min (w_at_min[g])
      );
    end
  endgenerate

  // Status flags: wrap and load-error are one-cycle pulses, sat is sticky
  // until a successful load or a step that really moves the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrap_p   <= 1'b0;
      r_sat      <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_wrap_p   <= w_wrap;
      r_load_err <= load & ~w_load_ok;
      if (w_load_do) begin
        r_sat <= 1'b0;
      end else if (w_blocked) begin
        r_sat <= 1'b1;
      end else if (w_step_en) begin
        r_sat <= 1'b0;
      end
    end
  end

  // Zero-latency terminal count so a following stage steps on this edge.
  assign tc       = w_count & w_at_end;
  assign wrap_p   = r_wrap_p;
  assign sat      = r_sat;
  assign load_err = r_load_err;

endmodule : bcd_counter_n

// File: tb/tb_bcd_counter_n.sv
// Bench for bcd_counter_n: four instances (4-digit wrap, 3-digit saturate,
// and a cascaded pair of 2-digit wrap counters) checked every cycle against
// an integer-valued reference model, plus directed scenarios.
module tb_bcd_counter_n;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // ---------------- DUT signals ----------------
  logic        x_a    [3];
  logic        down_a [3];
  logic        load_a [4];
  logic [15:0] lv0;
  logic [11:0] lv1;
  logic [7:0]  lv2, lv3;
  logic [15:0] bo0;
  logic [11:0] bo1;
  logic [7:0]  bo2, bo3;
  logic        tc_w  [4];
  logic        wp_w  [4];
  logic        sat_w [4];
  logic        le_w  [4];

  int vectors     = 0;
  int miscompares = 0;

  bcd_counter_n #(.DIGITS(4), .WRAP(1'b1)) u_d4 (
    .clk(clk), .reset(rst), .x(x_a[0]), .down(down_a[0]), .load(load_a[0]),
    .load_val(lv0), .bcd_out(bo0), .tc(tc_w[0]), .wrap_p(wp_w[0]),
    .sat(sat_w[0]), .load_err(le_w[0]));

  bcd_counter_n #(.DIGITS(3), .WRAP(1'b0)) u_d3s (
    .clk(clk), .reset(rst), .x(x_a[1]), .down(down_a[1]), .load(load_a[1]),
    .load_val(lv1), .bcd_out(bo1), .tc(tc_w[1]), .wrap_p(wp_w[1]),
    .sat(sat_w[1]), .load_err(le_w[1]));

  bcd_counter_n #(.DIGITS(2), .WRAP(1'b1)) u_lo (
    .clk(clk), .reset(rst), .x(x_a[2]), .down(down_a[2]), .load(load_a[2]),
    .load_val(lv2), .bcd_out(bo2), .tc(tc_w[2]), .wrap_p(wp_w[2]),
    .sat(sat_w[2]), .load_err(le_w[2]));

  bcd_counter_n #(.DIGITS(2), .WRAP(1'b1)) u_hi (
    .clk(clk), .reset(rst), .x(tc_w[2]), .down(down_a[2]), .load(load_a[3]),
    .load_val(lv3), .bcd_out(bo3), .tc(tc_w[3]), .wrap_p(wp_w[3]),
    .sat(sat_w[3]), .load_err(le_w[3]));

  // ---------------- reference model ----------------
  int m_v   [4];
  bit m_wp  [4];
  bit m_sat [4];
  bit m_le  [4];

  function automatic int dig(input int i);
    case (i)
      0:       return 4;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  function automatic bit wr(input int i);
    return (i != 1);
  endfunction

  function automatic int pow10(input int d);
    int r = 1;
    for (int k = 0; k < d; k++) r = r * 10;
    return r;
  endfunction

  function automatic logic [31:0] to_bcd(input int v, input int d);
    logic [31:0] r = '0;
    int t = v;
    for (int k = 0; k < d; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd(input logic [31:0] b, input int d);
    int r = 0;
    for (int k = d - 1; k >= 0; k--) r = r * 10 + int'(b[4*k +: 4]);
    return r;
  endfunction

  function automatic bit bcd_ok(input logic [31:0] b, input int d);
    for (int k = 0; k < d; k++) if (b[4*k +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] get_lv(input int i);
    case (i)
      0:       return 32'(lv0);
      1:       return 32'(lv1);
      2:       return 32'(lv2);
      default: return 32'(lv3);
    endcase
  endfunction

  function automatic logic [31:0] get_bo(input int i);
    case (i)
      0:       return 32'(bo0);
      1:       return 32'(bo1);
      2:       return 32'(bo2);
      default: return 32'(bo3);
    endcase
  endfunction

  function automatic bit get_down(input int i);
    return (i == 3) ? down_a[2] : down_a[i];
  endfunction

  // Expected terminal count from the model value and current inputs.
  function automatic bit exp_tc(input int i, input bit xin);
    bit at_end;
    at_end = get_down(i) ? (m_v[i] == 0) : (m_v[i] == pow10(dig(i)) - 1);
    return xin & ~load_a[i] & at_end;
  endfunction

  // Advance the model of instance i by one clock edge.
  task automatic model_step(input int i, input bit xin);
    int maxv;
    maxv = pow10(dig(i)) - 1;
    if (rst) begin
      m_v[i] = 0; m_wp[i] = 0; m_sat[i] = 0; m_le[i] = 0;
    end else begin
      m_wp[i] = 0;
      m_le[i] = 0;
      if (load_a[i]) begin
        if (bcd_ok(get_lv(i), dig(i))) begin
          m_v[i]   = from_bcd(get_lv(i), dig(i));
          m_sat[i] = 0;
        end else begin
          m_le[i] = 1;
        end
      end else if (xin) begin
        if (get_down(i)) begin
          if (m_v[i] == 0) begin
            if (wr(i)) begin m_v[i] = maxv; m_wp[i] = 1; end
            else       m_sat[i] = 1;
          end else begin
            m_v[i] = m_v[i] - 1; m_sat[i] = 0;
          end
        end else begin
          if (m_v[i] == maxv) begin
            if (wr(i)) begin m_v[i] = 0; m_wp[i] = 1; end
            else       m_sat[i] = 1;
          end else begin
            m_v[i] = m_v[i] + 1; m_sat[i] = 0;
          end
        end
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input int i, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s[%0d] got=%h expected=%h", tag, i, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Inputs are set by the caller just after an edge; tick checks tc before
  // the next edge, advances the model across it, then checks outputs.
  task automatic tick();
    bit xe [4];
    #1;
    for (int i = 0; i < 3; i++) xe[i] = x_a[i];
    xe[3] = exp_tc(2, x_a[2]);
    for (int i = 0; i < 4; i++) check("tc", i, 32'(tc_w[i]), 32'(exp_tc(i, xe[i])));
    @(posedge clk);
    for (int i = 0; i < 4; i++) model_step(i, xe[i]);
    #1;
    for (int i = 0; i < 4; i++) begin
      check("bcd_out",  i, get_bo(i), to_bcd(m_v[i], dig(i)));
      check("wrap_p",   i, 32'(wp_w[i]),  32'(m_wp[i]));
      check("sat",      i, 32'(sat_w[i]), 32'(m_sat[i]));
      check("load_err", i, 32'(le_w[i]),  32'(m_le[i]));
    end
  endtask

  task automatic idle();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) x_a[i] = 1'b0;
    for (int i = 0; i < 4; i++) load_a[i] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 4; i++) begin
      m_v[i] = 0; m_wp[i] = 0; m_sat[i] = 0; m_le[i] = 0;
    end
    for (int i = 0; i < 3; i++) down_a[i] = 1'b0;
    lv0 = '0; lv1 = '0; lv2 = '0; lv3 = '0;
    idle();
    rst = 1'b1;
    @(posedge clk);
    tick();
    check("reset_out", 0, 32'(bo0), 32'h0);

    // Reset in the middle of counting, then ten steps.
    idle();
    x_a[0] = 1'b1;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    check("mid_reset", 0, 32'(bo0), 32'h0);
    check("mid_reset_wp", 0, 32'(wp_w[0]), 32'h0);
    rst = 1'b0;
    repeat (10) tick();
    check("ten_steps", 0, 32'(bo0), 32'h0010);
    idle();

    // Up wrap on the 2-digit counter.
    load_a[2] = 1'b1; lv2 = 8'h98;
    tick();
    idle();
    x_a[2] = 1'b1; down_a[2] = 1'b0;
    tick();
    check("up_99", 2, 32'(bo2), 32'h99);
    #1;
    check("tc_at_99", 2, 32'(tc_w[2]), 32'h1);
    tick();
    check("up_wrap", 2, 32'(bo2), 32'h00);
    check("up_wrap_p", 2, 32'(wp_w[2]), 32'h1);
    idle();

    // Down saturate on the 3-digit counter.
    load_a[1] = 1'b1; lv1 = 12'h001;
    tick();
    idle();
    x_a[1] = 1'b1; down_a[1] = 1'b1;
    tick();
    check("down_000", 1, 32'(bo1), 32'h000);
    tick();
    check("sat_hold", 1, 32'(bo1), 32'h000);
    check("sat_set", 1, 32'(sat_w[1]), 32'h1);
    down_a[1] = 1'b0;
    tick();
    check("sat_rev", 1, 32'(bo1), 32'h001);
    check("sat_clr", 1, 32'(sat_w[1]), 32'h0);
    idle();

    // Invalid load rejected, valid load accepted.
    load_a[0] = 1'b1; lv0 = 16'h1234;
    tick();
    lv0 = 16'h12A4;
    tick();
    check("bad_load_hold", 0, 32'(bo0), 32'h1234);
    check("bad_load_err", 0, 32'(le_w[0]), 32'h1);
    lv0 = 16'h5678;
    tick();
    check("good_load", 0, 32'(bo0), 32'h5678);
    check("err_cleared", 0, 32'(le_w[0]), 32'h0);

    // Load and count in the same cycle: load wins.
    x_a[0] = 1'b1; down_a[0] = 1'b0; lv0 = 16'h0005;
    tick();
    check("collision", 0, 32'(bo0), 32'h0005);
    check("collision_wp", 0, 32'(wp_w[0]), 32'h0);
    idle();

    // Two-instance cascade across the 99 -> 00 boundary and back.
    load_a[2] = 1'b1; lv2 = 8'h99;
    load_a[3] = 1'b1; lv3 = 8'h07;
    tick();
    idle();
    x_a[2] = 1'b1; down_a[2] = 1'b0;
    tick();
    check("casc_lo_up", 2, 32'(bo2), 32'h00);
    check("casc_hi_up", 3, 32'(bo3), 32'h08);
    down_a[2] = 1'b1;
    tick();
    check("casc_lo_dn", 2, 32'(bo2), 32'h99);
    check("casc_hi_dn", 3, 32'(bo3), 32'h07);
    idle();

    // Randomised traffic on all instances.
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 79) == 0);
      for (int i = 0; i < 3; i++) begin
        x_a[i] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 15) == 0) down_a[i] = ~down_a[i];
      end
      for (int i = 0; i < 4; i++) begin
        logic [31:0] v;
        int sel;
        load_a[i] = ($urandom_range(0, 11) == 0);
        sel = $urandom_range(0, 3);
        case (sel)
          0:       v = to_bcd(0, dig(i));
          1:       v = to_bcd(pow10(dig(i)) - 1, dig(i));
          2:       v = to_bcd($urandom_range(0, pow10(dig(i)) - 1), dig(i));
          default: v = $urandom;
        endcase
        case (i)
          0:       lv0 = v[15:0];
          1:       lv1 = v[11:0];
          2:       lv2 = v[7:0];
          default: lv3 = v[7:0];
        endcase
      end
      tick();
    end
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_bcd_counter_n
